// File: rtl/vga_rect_fill.sv
// Rectangle fill engine for the 160x120 VGA adapter.
// Sweeps a clipped rectangle in raster order, one pixel per clock.
module vga_rect_fill #(
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int CW    = 3,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    input  logic [CW-1:0] colour,
    input  logic          stall,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour_out,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAW,
        FIN
    } state_t;

    localparam logic [XW:0] XLIM = (XW+1)'(X_MAX);
    localparam logic [YW:0] YLIM = (YW+1)'(Y_MAX);

    state_t        state;
    logic [XW-1:0] cmd_x0;
    logic [YW-1:0] cmd_y0;
    logic [XW-1:0] cmd_w;
    logic [YW-1:0] cmd_h;
    logic [CW-1:0] cmd_col;
    logic [XW-1:0] xe;
    logic [YW-1:0] ye;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;

    logic [XW:0]   x_end;
    logic [YW:0]   y_end;
    logic [XW-1:0] xe_c;
    logic [YW-1:0] ye_c;
    logic          empty;

    // Clipped extents from the latched command, one bit wider so nothing wraps
    always_comb begin
        x_end = {1'b0, cmd_x0} + {1'b0, cmd_w} - (XW+1)'(1);
        y_end = {1'b0, cmd_y0} + {1'b0, cmd_h} - (YW+1)'(1);
        xe_c  = (x_end > XLIM) ? XW'(X_MAX) : x_end[XW-1:0];
        ye_c  = (y_end > YLIM) ? YW'(Y_MAX) : y_end[YW-1:0];
        empty = (cmd_w == '0) || (cmd_h == '0)
             || ({1'b0, cmd_x0} > XLIM)
             || ({1'b0, cmd_y0} > YLIM);
    end

    // Command FSM and registered pixel outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cmd_x0     <= '0;
            cmd_y0     <= '0;
            cmd_w      <= '0;
            cmd_h      <= '0;
            cmd_col    <= '0;
            xe         <= '0;
            ye         <= '0;
            cx         <= '0;
            cy         <= '0;
            x          <= '0;
            y          <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        cmd_x0  <= x0;
                        cmd_y0  <= y0;
                        cmd_w   <= w;
                        cmd_h   <= h;
                        cmd_col <= colour;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    xe    <= xe_c;
                    ye    <= ye_c;
                    cx    <= cmd_x0;
                    cy    <= cmd_y0;
                    state <= empty ? FIN : DRAW;
                end
                DRAW: begin
                    if (stall) begin
                        plot <= 1'b0;
                    end else begin
                        x          <= cx;
                        y          <= cy;
                        colour_out <= cmd_col;
                        plot       <= 1'b1;
                        if (cx == xe) begin
                            if (cy == ye) begin
                                state <= FIN;
                            end else begin
                                cx <= cmd_x0;
                                cy <= cy + YW'(1);
                            end
                        end else begin
                            cx <= cx + XW'(1);
                        end
                    end
                end
                FIN: begin
                    plot  <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill.
// Random and directed fills against a raster-order pixel model.
module tb_vga_rect_fill;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] x0 = '0;
    logic [6:0] y0 = '0;
    logic [7:0] w = '0;
    logic [6:0] h = '0;
    logic [2:0] colour = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour_out;
    logic       plot;
    logic       busy;
    logic       done;

    vga_rect_fill dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .w         (w),
        .h         (h),
        .colour    (colour),
        .stall     (stall),
        .x         (x),
        .y         (y),
        .colour_out(colour_out),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: every in-frame pixel of the rectangle, x fastest
    task automatic model(input int ax0, input int ay0, input int aw,
                         input int ah, input int ac, output int n);
        pix_t p;
        n = 0;
        for (int yy = ay0; yy < ay0 + ah; yy++) begin
            if (yy > 119) break;
            for (int xx = ax0; xx < ax0 + aw; xx++) begin
                if (xx > 159) break;
                p.px = xx;
                p.py = yy;
                p.pc = ac;
                exp_q.push_back(p);
                n++;
            end
        end
    endtask

    // Pixel content compare on every cycle
    always @(posedge clk) begin
        logic st;
        pix_t p;
        st = stall;
        #1;
        if (reset) begin
            if (plot) begin
                chk("plot_not_stalled", {31'd0, st}, 0);
                chk("plot_expected", exp_q.size() > 0, 1);
                chk("x_in_frame", x <= 8'd159, 1);
                chk("y_in_frame", y <= 7'd119, 1);
                if (exp_q.size() > 0) begin
                    p = exp_q.pop_front();
                    chk("pix_x", {24'd0, x}, p.px);
                    chk("pix_y", {25'd0, y}, p.py);
                    chk("pix_col", {29'd0, colour_out}, p.pc);
                end
            end
            if (done) chk("done_all_drawn", exp_q.size(), 0);
            chk("done_one_cycle", {31'd0, prev_done & done}, 0);
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Issue one command and check plot/done/busy cycle by cycle.
    // smode: 0 no stall, 1 random stall, 2 stall on edges s_lo..s_hi.
    task automatic run_cmd(input int ax0, input int ay0, input int aw,
                           input int ah, input int ac, input int smode,
                           input int s_lo, input int s_hi,
                           input int bstart, input int abort_k,
                           output int first_k, output int done_k,
                           output int nplot);
        int   p;
        int   k;
        int   emitted;
        int   last_k;
        logic s;
        logic ep;
        logic ed;
        model(ax0, ay0, aw, ah, ac, p);
        x0 = 8'(ax0);
        y0 = 7'(ay0);
        w = 8'(aw);
        h = 7'(ah);
        colour = 3'(ac);
        start = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        start = 1'b0;
        x0 = 8'($urandom);
        y0 = 7'($urandom);
        w = 8'($urandom);
        h = 7'($urandom);
        colour = 3'($urandom);
        chk("busy_after_start", {31'd0, busy}, 1);
        k = 0;
        emitted = 0;
        last_k = -1;
        first_k = -1;
        done_k = -1;
        nplot = 0;
        while (k < 1000) begin
            if (smode == 1) s = ($urandom_range(0, 3) == 0);
            else if (smode == 2) s = (k + 1 >= s_lo) && (k + 1 <= s_hi);
            else s = 1'b0;
            stall = s;
            if (bstart != 0 && $urandom_range(0, 2) == 0) begin
                start = 1'b1;
                x0 = 8'($urandom_range(0, 40));
                y0 = 7'($urandom_range(0, 40));
                w = 8'($urandom_range(1, 5));
                h = 7'($urandom_range(1, 5));
                colour = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
            ep = (k >= 2) && !s && (emitted < p);
            if (ep) begin
                emitted++;
                if (first_k < 0) first_k = k;
                if (emitted == p) last_k = k;
            end
            ed = (p == 0) ? (k == 2) : (last_k >= 0 && k == last_k + 1);
            chk("plot_timing", {31'd0, plot}, {31'd0, ep});
            chk("done_timing", {31'd0, done}, {31'd0, ed});
            chk("busy_timing", {31'd0, busy}, {31'd0, !ed});
            if (plot) nplot++;
            if (ed) begin
                done_k = k;
                break;
            end
            if (abort_k > 0 && k == abort_k) begin
                #2 reset = 1'b0;
                #1;
                chk("rst_x", {24'd0, x}, 0);
                chk("rst_y", {25'd0, y}, 0);
                chk("rst_col", {29'd0, colour_out}, 0);
                chk("rst_plot", {31'd0, plot}, 0);
                chk("rst_busy", {31'd0, busy}, 0);
                chk("rst_done", {31'd0, done}, 0);
                exp_q.delete();
                start = 1'b0;
                stall = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("no_done_after_rst", {31'd0, done}, 0);
                    chk("idle_after_rst", {31'd0, busy | plot}, 0);
                end
                return;
            end
        end
        start = 1'b0;
        stall = 1'b0;
        chk("done_seen", done_k >= 0, 1);
        chk("plot_count", nplot, p);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fk;
        int dk;
        int np;
        int rx;
        int ry;
        int rw;
        int rh;

        // Model pinned against hand-computed pixel lists
        model(10, 5, 2, 2, 5, n);
        chk("pin_basic_n", n, 4);
        chk("pin_basic_x2", exp_q[2].px, 10);
        chk("pin_basic_y2", exp_q[2].py, 6);
        chk("pin_basic_x1", exp_q[1].px, 11);
        exp_q.delete();
        model(158, 118, 4, 4, 1, n);
        chk("pin_clip_n", n, 4);
        chk("pin_clip_x3", exp_q[3].px, 159);
        chk("pin_clip_y3", exp_q[3].py, 119);
        exp_q.delete();
        model(160, 0, 4, 2, 1, n);
        chk("pin_empty_n", n, 0);
        exp_q.delete();

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_plot", {31'd0, plot}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_xy", {17'd0, x, y}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Basic 2x2
        run_cmd(10, 5, 2, 2, 5, 0, 0, 0, 0, 0, fk, dk, np);
        chk("basic_first", fk, 2);
        chk("basic_done", dk, 6);
        chk("basic_plots", np, 4);
        @(negedge clk);

        // Empty commands
        run_cmd(20, 20, 0, 3, 2, 0, 0, 0, 0, 0, fk, dk, np);
        chk("empty_w_done", dk, 2);
        chk("empty_w_plots", np, 0);
        run_cmd(160, 4, 4, 2, 2, 0, 0, 0, 0, 0, fk, dk, np);
        chk("empty_x_done", dk, 2);
        chk("empty_x_plots", np, 0);

        // Clipping at the bottom-right corner
        run_cmd(158, 118, 4, 4, 3, 0, 0, 0, 0, 0, fk, dk, np);
        chk("clip_plots", np, 4);
        chk("clip_done", dk, 6);

        // Two stall cycles right after the first pixel
        run_cmd(0, 0, 3, 1, 6, 2, 3, 4, 0, 0, fk, dk, np);
        chk("stall_done", dk, 7);
        chk("stall_plots", np, 3);

        // Start while busy ignored, next start straight after done accepted
        run_cmd(30, 40, 3, 2, 4, 0, 0, 0, 1, 0, fk, dk, np);
        chk("busy_start_done", dk, 8);
        run_cmd(50, 60, 2, 1, 1, 0, 0, 0, 0, 0, fk, dk, np);
        chk("back2back_done", dk, 4);

        // Reset mid-fill, then a 1x1 fill
        run_cmd(2, 3, 4, 4, 6, 0, 0, 0, 0, 4, fk, dk, np);
        run_cmd(7, 7, 1, 1, 7, 0, 0, 0, 0, 0, fk, dk, np);
        chk("after_rst_plots", np, 1);
        chk("after_rst_done", dk, 3);

        // Randomized commands
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rx = $urandom_range(145, 170);
                ry = $urandom_range(105, 127);
                rw = $urandom_range(0, 30);
                rh = $urandom_range(0, 20);
            end else begin
                rx = $urandom_range(0, 150);
                ry = $urandom_range(0, 110);
                rw = $urandom_range(0, 12);
                rh = $urandom_range(0, 6);
            end
            run_cmd(rx, ry, rw, rh, $urandom_range(0, 7),
                    $urandom_range(0, 1), 0, 0,
                    $urandom_range(0, 1), 0, fk, dk, np);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
